ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte to the mouse, for example 0xFF reset or 0xF4 enable data reporting, and checks the device's acknowledge bit. It drives the open-drain PS2_CLK/PS2_DAT lines through output-enable signals; the top level ties each line to 1'b0 when its enable is high and 1'bz otherwise. It runs alongside the existing PS/2 receive path, and that path must ignore line activity while `tx_busy` is high.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmit path.
//   - ps2_tx_state_t : transmitter FSM states
//   - PS2_CMD_* / PS2_RESP_ACK : common mouse command and response bytes
//   - PS2_*_DEF      : default timing constants at a 50 MHz clock
//   - odd_parity()   : parity bit appended to every host-to-device frame
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

  localparam int PS2_CLK_INHIBIT_DEF = 6000;    // 120 us
  localparam int PS2_DATA_SETUP_DEF  = 100;     // 2 us
  localparam int PS2_TIMEOUT_DEF     = 750000;  // 15 ms

  // Odd parity: the nine bits (data + parity) always hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings one open-drain PS/2 line into the CLOCK_50 domain.
//   CLOCK_50 : system clock
//   reset    : asynchronous, active-high
//   line_in  : raw line level (asynchronous)
//   line_s   : level after a 2-flop synchronizer
//   fall_s   : one-cycle pulse, 3 cycles after a 1->0 line transition
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line_in,
  output logic line_s,
  output logic fall_s
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic fall_r;

  // Synchronizer chain plus registered falling-edge detect; idle level of the bus is 1.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      meta_r <= line_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      fall_r <= prev_r & ~sync_r;
    end
  end

  assign line_s = sync_r;
  assign fall_s = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device and
// checks the device's acknowledge bit.
//   CLOCK_50               : system clock
//   reset                  : asynchronous, active-high
//   cmd_data / cmd_valid   : command byte offer
//   cmd_ready              : high only while idle; accept = cmd_valid && cmd_ready
//   ps2_clk_in, ps2_dat_in : raw line levels (asynchronous)
//   ps2_clk_oe, ps2_dat_oe : 1 pulls the corresponding line low
//   tx_busy                : high whenever a transfer is in progress
//   tx_done                : one-cycle pulse, device acknowledged (ack = 0)
//   tx_error / err_timeout : one-cycle failure pulse; err_timeout=1 timeout,
//                            0 NACK; err_timeout holds until the next accept
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_INHIBIT_CYCLES = PS2_CLK_INHIBIT_DEF,
  parameter int DATA_SETUP_CYCLES  = PS2_DATA_SETUP_DEF,
  parameter int TIMEOUT_CYCLES     = PS2_TIMEOUT_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       err_timeout
);

  localparam int INH_W = $clog2(CLK_INHIBIT_CYCLES + 1);
  localparam int SET_W = $clog2(DATA_SETUP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DATA_SETUP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  logic clk_line_s;
  logic clk_fall_s;
  logic dat_line_s;
  logic dat_fall_s;

  ps2_tx_state_t    state_r, state_s;
  logic [7:0]       byte_r, byte_s;
  logic             parity_r, parity_s;
  logic             ack_r, ack_s;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
  logic [SET_W-1:0] set_cnt_r, set_cnt_s;
  logic [WD_W-1:0]  wd_cnt_r, wd_cnt_s;
  logic [3:0]       bit_cnt_r, bit_cnt_s;
  logic             dat_drive_s;
  logic             done_s, error_s, err_to_s;

  logic clk_oe_r, dat_oe_r, busy_r, ready_r, done_r, error_r, err_to_r;

  ps2_line_sync u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_clk_in),
    .line_s   (clk_line_s),
    .fall_s   (clk_fall_s)
  );

  ps2_line_sync u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_dat_in),
    .line_s   (dat_line_s),
    .fall_s   (dat_fall_s)
  );

  // Next-state, datapath and output-pulse logic of the transmit FSM.
  always_comb begin
    state_s     = state_r;
    byte_s      = byte_r;
    parity_s    = parity_r;
    ack_s       = ack_r;
    inh_cnt_s   = inh_cnt_r;
    set_cnt_s   = set_cnt_r;
    wd_cnt_s    = wd_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    dat_drive_s = dat_oe_r;
    done_s      = 1'b0;
    error_s     = 1'b0;
    err_to_s    = err_to_r;

    case (state_r)
      IDLE: begin
        if (cmd_valid && ready_r) begin
          state_s   = INHIBIT;
          byte_s    = cmd_data;
          parity_s  = odd_parity(cmd_data);
          err_to_s  = 1'b0;
          inh_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end

      INHIBIT: begin
        if (inh_cnt_r == INH_LAST) begin
          state_s     = START;
          set_cnt_s   = '0;
          dat_drive_s = 1'b1;
        end else begin
          inh_cnt_s = inh_cnt_r + 1'b1;
        end
      end

      START: begin
        // Start bit is 0: keep data pulled low, then release the clock.
        dat_drive_s = 1'b1;
        if (set_cnt_r == SET_LAST) begin
          state_s   = SEND;
          wd_cnt_s  = '0;
          bit_cnt_s = 4'd0;
        end else begin
          set_cnt_s = set_cnt_r + 1'b1;
        end
      end

      SEND: begin
        // Watchdog is checked first so it wins over a coincident 11th edge.
        if (wd_cnt_r == WD_LAST) begin
          state_s     = IDLE;
          error_s     = 1'b1;
          err_to_s    = 1'b1;
          dat_drive_s = 1'b0;
        end else begin
          wd_cnt_s = wd_cnt_r + 1'b1;
          if (clk_fall_s) begin
            bit_cnt_s = (bit_cnt_r == 4'd11) ? 4'd11 : bit_cnt_r + 4'd1;
            // bit_cnt_r counts edges already seen, so this is edge k = bit_cnt_r + 1.
            case (bit_cnt_r)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: dat_drive_s = ~byte_r[bit_cnt_r[2:0]];
              4'd8:    dat_drive_s = ~parity_r;
              4'd9:    dat_drive_s = 1'b0;
              4'd10: begin
                dat_drive_s = 1'b0;
                ack_s       = dat_line_s;
                state_s     = WAIT_IDLE;
              end
              default: dat_drive_s = 1'b0;
            endcase
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end
      end

      WAIT_IDLE: begin
        dat_drive_s = 1'b0;
        if (wd_cnt_r == WD_LAST) begin
          state_s  = IDLE;
          error_s  = 1'b1;
          err_to_s = 1'b1;
        end else begin
          wd_cnt_s = wd_cnt_r + 1'b1;
          // A data fall registered this cycle means the line was low a moment
          // ago; give the bus one more cycle to settle before calling it idle.
          if (clk_line_s && dat_line_s && !dat_fall_s) begin
            state_s = IDLE;
            if (ack_r) begin
              error_s  = 1'b1;
              err_to_s = 1'b0;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            state_s = WAIT_IDLE;
          end
        end
      end

      default: begin
        state_s     = IDLE;
        dat_drive_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      byte_r    <= 8'h00;
      parity_r  <= 1'b0;
      ack_r     <= 1'b0;
      inh_cnt_r <= '0;
      set_cnt_r <= '0;
      wd_cnt_r  <= '0;
      bit_cnt_r <= 4'd0;
      clk_oe_r  <= 1'b0;
      dat_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      err_to_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      byte_r    <= byte_s;
      parity_r  <= parity_s;
      ack_r     <= ack_s;
      inh_cnt_r <= inh_cnt_s;
      set_cnt_r <= set_cnt_s;
      wd_cnt_r  <= wd_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      clk_oe_r  <= (state_s == INHIBIT) || (state_s == START);
      dat_oe_r  <= ((state_s == IDLE) || (state_s == INHIBIT)) ? 1'b0 : dat_drive_s;
      busy_r    <= (state_s != IDLE);
      ready_r   <= (state_s == IDLE);
      done_r    <= done_s;
      error_r   <= error_s;
      err_to_r  <= err_to_s;
    end
  end

  assign cmd_ready   = ready_r;
  assign tx_busy     = busy_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_dat_oe  = dat_oe_r;
  assign tx_done     = done_r;
  assign tx_error    = error_r;
  assign err_timeout = err_to_r;

endmodule
